// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg
//   Shared definitions for the pulse window sequencer: FSM state encoding and
//   the default width parameters used by the top level and its counters.
//   No ports (package).
package pulse_seq_pkg;

   // Sequencer states, one per phase of a pattern exposure.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TRIG   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_COUNT  = 3'd3,
      ST_REPORT = 3'd4,
      ST_FIN    = 3'd5
   } seq_state_t;

   // Default widths.
   localparam int DEF_N_CH     = 2;
   localparam int DEF_CNT_W    = 16;
   localparam int DEF_WIN_W    = 32;
   localparam int DEF_SETTLE_W = 16;
   localparam int DEF_IDX_W    = 16;

endpackage

// File: rtl/pulse_window_counter.sv
// pulse_window_counter
//   CNT_W-bit saturating event counter with synchronous clear and a sticky
//   saturation flag.
// Ports:
//   clk    in  1      clock
//   rst    in  1      synchronous active-high reset
//   clr    in  1      synchronous clear of count and flag
//   en     in  1      increment request for this cycle
//   count  out CNT_W  current count, stops at all-ones
//   sat    out 1      set once the count has reached all-ones
module pulse_window_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_r;
   logic             sat_r;

   // Count enabled events, holding at all-ones; flag records reaching the top.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_r <= '0;
         sat_r   <= 1'b0;
      end else if (en && (count_r != CNT_MAX)) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         sat_r   <= (count_r == CNT_NEAR);
      end else begin
         count_r <= count_r;
         sat_r   <= sat_r;
      end
   end

   assign count = count_r;
   assign sat   = sat_r;

endmodule

// File: rtl/pulse_window_sequencer.sv
// pulse_window_sequencer
//   Per pattern: strobe pattern_trig, wait settle_len cycles, count shaped
//   pulses per channel for win_len cycles, then present the result on a
//   valid/ready stream. Repeats n_patterns times and strobes done.
//   Optional feature macro: PULSE_SEQ_COINC_EN adds a counter of COUNT cycles
//   where every channel pulses together; without it res_coinc is tied to 0.
// Ports:
//   clk, rst (sync, active-high), start, abort, win_len, settle_len,
//   n_patterns, pulse_in[N_CH], pattern_trig, busy, res_valid, res_ready,
//   res_index, res_counts[N_CH*CNT_W], res_sat[N_CH], res_coinc, done
module pulse_window_sequencer
   import pulse_seq_pkg::*;
#(
   parameter int N_CH     = DEF_N_CH,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int WIN_W    = DEF_WIN_W,
   parameter int SETTLE_W = DEF_SETTLE_W,
   parameter int IDX_W    = DEF_IDX_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WIN_W-1:0]      win_len,
   input  logic [SETTLE_W-1:0]   settle_len,
   input  logic [IDX_W-1:0]      n_patterns,
   input  logic [N_CH-1:0]       pulse_in,
   output logic                  pattern_trig,
   output logic                  busy,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [IDX_W-1:0]      res_index,
   output logic [N_CH*CNT_W-1:0] res_counts,
   output logic [N_CH-1:0]       res_sat,
   output logic [CNT_W-1:0]      res_coinc,
   output logic                  done
);

   seq_state_t        state_r;
   logic [WIN_W-1:0]  win_len_r;
   logic [SETTLE_W-1:0] settle_len_r;
   logic [IDX_W-1:0]  n_pat_r;
   logic [IDX_W-1:0]  index_r;
   logic [WIN_W-1:0]  timer_r;
   logic              pattern_trig_r;
   logic              busy_r;
   logic              res_valid_r;
   logic              done_r;

   logic              cnt_clr_s;
   logic              cnt_en_s;

   // Counters are wiped by reset, abort and at the start of every pattern.
   assign cnt_clr_s = abort || (state_r == ST_TRIG);
   assign cnt_en_s  = (state_r == ST_COUNT);

   // Sequencer FSM with registered strobes and the shared settle/window timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         win_len_r      <= '0;
         settle_len_r   <= '0;
         n_pat_r        <= '0;
         index_r        <= '0;
         timer_r        <= '0;
         pattern_trig_r <= 1'b0;
         busy_r         <= 1'b0;
         res_valid_r    <= 1'b0;
         done_r         <= 1'b0;
      end else if (abort) begin
         state_r        <= ST_IDLE;
         index_r        <= '0;
         timer_r        <= '0;
         pattern_trig_r <= 1'b0;
         busy_r         <= 1'b0;
         res_valid_r    <= 1'b0;
         done_r         <= 1'b0;
      end else begin
         pattern_trig_r <= 1'b0;
         done_r         <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  // A zero window still counts for one cycle.
                  win_len_r    <= (win_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : win_len;
                  settle_len_r <= settle_len;
                  n_pat_r      <= n_patterns;
                  index_r      <= '0;
                  busy_r       <= 1'b1;
                  if (n_patterns == '0) begin
                     state_r <= ST_FIN;
                     done_r  <= 1'b1;
                  end else begin
                     state_r        <= ST_TRIG;
                     pattern_trig_r <= 1'b1;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_TRIG: begin
               // Timer is loaded with length-1 so it expires on the last cycle.
               if (settle_len_r == '0) begin
                  state_r <= ST_COUNT;
                  timer_r <= win_len_r - {{(WIN_W-1){1'b0}}, 1'b1};
               end else begin
                  state_r <= ST_SETTLE;
                  timer_r <= WIN_W'(settle_len_r) - {{(WIN_W-1){1'b0}}, 1'b1};
               end
            end
            ST_SETTLE: begin
               if (timer_r == '0) begin
                  state_r <= ST_COUNT;
                  timer_r <= win_len_r - {{(WIN_W-1){1'b0}}, 1'b1};
               end else begin
                  timer_r <= timer_r - {{(WIN_W-1){1'b0}}, 1'b1};
               end
            end
            ST_COUNT: begin
               if (timer_r == '0) begin
                  state_r     <= ST_REPORT;
                  res_valid_r <= 1'b1;
               end else begin
                  timer_r <= timer_r - {{(WIN_W-1){1'b0}}, 1'b1};
               end
            end
            ST_REPORT: begin
               if (res_ready) begin
                  res_valid_r <= 1'b0;
                  if (index_r == (n_pat_r - {{(IDX_W-1){1'b0}}, 1'b1})) begin
                     state_r <= ST_FIN;
                     done_r  <= 1'b1;
                  end else begin
                     index_r        <= index_r + {{(IDX_W-1){1'b0}}, 1'b1};
                     state_r        <= ST_TRIG;
                     pattern_trig_r <= 1'b1;
                  end
               end else begin
                  res_valid_r <= 1'b1;
               end
            end
            ST_FIN: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // One saturating counter per channel; results sit directly in the counters.
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      pulse_window_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr   (cnt_clr_s),
         .en    (cnt_en_s && pulse_in[k]),
         .count (res_counts[k*CNT_W +: CNT_W]),
         .sat   (res_sat[k])
      );
   end

`ifdef PULSE_SEQ_COINC_EN
   logic coinc_sat_s;

   // Coincidence: every channel high in the same COUNT cycle.
   pulse_window_counter #(.CNT_W(CNT_W)) u_coinc (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr_s),
      .en    (cnt_en_s && (&pulse_in)),
      .count (res_coinc),
      .sat   (coinc_sat_s)
   );
`else
   assign res_coinc = '0;
`endif

   assign pattern_trig = pattern_trig_r;
   assign busy         = busy_r;
   assign res_valid    = res_valid_r;
   assign res_index    = index_r;
   assign done         = done_r;

endmodule

// File: tb/tb_pulse_window_sequencer.sv
// tb_pulse_window_sequencer
//   Self-checking bench: directed scenarios plus randomized runs, predicted
//   from exposure timing arithmetic (trigger, S settle cycles, W counting
//   cycles, report until handshake). CNT_W=4 so saturation is reachable.
module tb_pulse_window_sequencer;

   localparam int N_CH  = 2;
   localparam int CNT_W = 4;
   localparam int WIN_W = 32;
   localparam int SET_W = 16;
   localparam int IDX_W = 16;
   localparam int CMAX  = 15;

   logic                  clk;
   logic                  rst;
   logic                  start;
   logic                  abort;
   logic [WIN_W-1:0]      win_len;
   logic [SET_W-1:0]      settle_len;
   logic [IDX_W-1:0]      n_patterns;
   logic [N_CH-1:0]       pulse_in;
   logic                  pattern_trig;
   logic                  busy;
   logic                  res_valid;
   logic                  res_ready;
   logic [IDX_W-1:0]      res_index;
   logic [N_CH*CNT_W-1:0] res_counts;
   logic [N_CH-1:0]       res_sat;
   logic [CNT_W-1:0]      res_coinc;
   logic                  done;

   int checks   = 0;
   int failures = 0;

   pulse_window_sequencer #(
      .N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_W(SET_W), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
      .settle_len(settle_len), .n_patterns(n_patterns), .pulse_in(pulse_in),
      .pattern_trig(pattern_trig), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .res_index(res_index), .res_counts(res_counts),
      .res_sat(res_sat), .res_coinc(res_coinc), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat_val(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // Checks the whole idle-after-clear picture (reset or abort).
   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"},   busy, 64'd0);
      chk({tag, "_valid"},  res_valid, 64'd0);
      chk({tag, "_trig"},   pattern_trig, 64'd0);
      chk({tag, "_done"},   done, 64'd0);
      chk({tag, "_counts"}, res_counts, 64'd0);
      chk({tag, "_sat"},    res_sat, 64'd0);
      chk({tag, "_index"},  res_index, 64'd0);
      chk({tag, "_coinc"},  res_coinc, 64'd0);
   endtask

   // One complete run. mode: 0 random pulses, 1 ch0 on first 4 window cycles,
   // 2 ch0 on every window cycle, 3 both channels on first 3 window cycles.
   // hold1 = cycles res_ready stays low for pattern 1 (-1: random).
   task automatic run(input int s, input int w, input int n, input int mode,
                      input int hold1, input string tag);
      int weff;
      int d;
      int c0, c1, cc, j;
      logic [N_CH-1:0] pv;
      bit hand;
      weff = (w == 0) ? 1 : w;
      start = 1'b1; abort = 1'b0; res_ready = 1'b0;
      settle_len = SET_W'(s); win_len = WIN_W'(w); n_patterns = IDX_W'(n);
      pulse_in = 2'b00;
      tick();
      start = 1'b0;
      // Lengths must have been latched; scramble the inputs.
      settle_len = SET_W'($urandom_range(0, 9));
      win_len    = WIN_W'($urandom_range(0, 9));
      n_patterns = IDX_W'($urandom_range(0, 9));
      if (n == 0) begin
         chk({tag, "_n0_done"},  done, 64'd1);
         chk({tag, "_n0_trig"},  pattern_trig, 64'd0);
         chk({tag, "_n0_valid"}, res_valid, 64'd0);
         tick();
         chk({tag, "_n0_busy_end"}, busy, 64'd0);
         chk({tag, "_n0_done_end"}, done, 64'd0);
         return;
      end
      for (int p = 0; p < n; p++) begin
         c0 = 0; c1 = 0; cc = 0;
         d = (p == 1 && hold1 >= 0) ? hold1 : int'($urandom_range(0, 3));
         hand = 1'b0;
         for (int i = 0; i < 2000 && !hand; i++) begin
            chk({tag, "_trig"},  pattern_trig, (i == 0) ? 64'd1 : 64'd0);
            chk({tag, "_busy"},  busy, 64'd1);
            chk({tag, "_done"},  done, 64'd0);
            chk({tag, "_valid"}, res_valid, (i > s + weff) ? 64'd1 : 64'd0);
            if (i > s + weff) begin
               chk({tag, "_index"},  res_index, 64'(p));
               chk({tag, "_counts"}, res_counts, {56'd0, 4'(sat_val(c1)), 4'(sat_val(c0))});
               chk({tag, "_sat"},    res_sat, {62'd0, (c1 >= CMAX), (c0 >= CMAX)});
`ifdef PULSE_SEQ_COINC_EN
               chk({tag, "_coinc"},  res_coinc, 64'(sat_val(cc)));
`else
               chk({tag, "_coinc"},  res_coinc, 64'd0);
`endif
            end
            // Pulse stimulus for this cycle.
            j = i - s - 1;
            pv = 2'($urandom_range(0, 3));
            if (j >= 0 && j < weff) begin
               if (mode == 1) pv = (j < 4) ? 2'b01 : 2'b00;
               else if (mode == 2) pv = 2'b01;
               else if (mode == 3) pv = (j < 3) ? 2'b11 : (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
               c0 += int'(pv[0]);
               c1 += int'(pv[1]);
               cc += int'(pv[0] & pv[1]);
            end
            pulse_in = pv;
            // Ignored restart attempts while busy.
            start = ($urandom_range(0, 5) == 0);
            if (i > s + weff) begin
               hand = (i == s + weff + 1 + d);
               res_ready = hand;
            end else begin
               res_ready = 1'($urandom_range(0, 1));
            end
            tick();
         end
         if (!hand) chk({tag, "_handshake_timeout"}, 64'd0, 64'd1);
      end
      start = 1'b0; res_ready = 1'b0; pulse_in = 2'b00;
      chk({tag, "_fin_done"},  done, 64'd1);
      chk({tag, "_fin_trig"},  pattern_trig, 64'd0);
      chk({tag, "_fin_valid"}, res_valid, 64'd0);
      chk({tag, "_fin_busy"},  busy, 64'd1);
      tick();
      chk({tag, "_end_busy"}, busy, 64'd0);
      chk({tag, "_end_done"}, done, 64'd0);
   endtask

   // Start a run, then abort (or reset) at cycle 'when' after the trigger.
   task automatic interrupt(input int when, input bit use_rst, input string tag);
      start = 1'b1; settle_len = 16'd2; win_len = 32'd6; n_patterns = 16'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < when; i++) begin
         pulse_in = 2'b11; res_ready = 1'b0;
         tick();
      end
      if (use_rst) rst = 1'b1; else abort = 1'b1;
      tick();
      rst = 1'b0; abort = 1'b0; pulse_in = 2'b00;
      chk_cleared(tag);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk({tag, "_no_done"}, done, 64'd0);
         chk({tag, "_stay_idle"}, busy, 64'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
      win_len = '0; settle_len = '0; n_patterns = '0; pulse_in = '0;
      tick();
      tick();
      chk_cleared("reset");
      rst = 1'b0;
      tick();

      // Basic exposure: S=3, W=10, ch0 pulses 4 times in the window.
      run(3, 10, 1, 1, -1, "t1");
      // Three patterns, consumer stalls 5 cycles on pattern 1.
      run(2, 5, 3, 0, 5, "t2");
      // Saturation: 20 pulses into a 4-bit counter.
      run(1, 20, 1, 2, -1, "t3");
      // Coincidences on exactly 3 window cycles.
      run(1, 8, 1, 3, -1, "t6");
      // Abort in COUNT (trig + 2 settle + 2 count) and in REPORT.
      interrupt(4, 1'b0, "abort_count");
      interrupt(10, 1'b0, "abort_report");
      run(1, 4, 2, 0, -1, "after_abort");
      // Abort together with start in IDLE.
      start = 1'b1; abort = 1'b1; n_patterns = 16'd1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("abort_start_busy", busy, 64'd0);
      chk("abort_start_trig", pattern_trig, 64'd0);
      // Reset mid-run.
      interrupt(5, 1'b1, "rst_mid");
      // Boundaries: n=0, W=0, S=0.
      run(2, 3, 0, 0, -1, "n0");
      run(2, 0, 1, 0, -1, "w0");
      run(0, 5, 2, 0, -1, "s0");
      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         run(int'($urandom_range(0, 4)), int'($urandom_range(0, 25)),
             int'($urandom_range(1, 3)), 0, -1, "rand");
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
